// File: rtl/le_pkg.sv
// Shared definitions for the compare datapath: default operand width and the
// window-extrema controller state encoding.
package le_pkg;

    localparam int LE_WIDTH = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } le_ext_state_t;

endpackage : le_pkg

// File: rtl/le_cell.sv
// LeCell: unsigned "a <= b" comparator, purely combinational.
module LeCell #(
    parameter int WIDTH = le_pkg::LE_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             le
);

    assign le = (a <= b);

endmodule : LeCell

// File: rtl/le_window_extrema.sv
// Streaming window min/max tracker: two LeCell compares per accepted sample,
// result (extrema, first-occurrence indices, count) held until consumed.
module le_window_extrema
    import le_pkg::*;
#(
    parameter  int WIDTH = LE_WIDTH,
    parameter  int WIN   = 8,
    localparam int CW    = $clog2(WIN + 1),
    localparam int IW    = $clog2(WIN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [IW-1:0]    out_min_idx,
    output logic [IW-1:0]    out_max_idx,
    output logic [CW-1:0]    out_count
);

    localparam logic [CW-1:0] LAST_COUNT = CW'(WIN - 1);

    le_ext_state_t    state, next_state;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] min_r, max_r;
    logic [IW-1:0]    min_idx_r, max_idx_r;

    logic [CW-1:0]    upd_count;
    logic [WIDTH-1:0] upd_min, upd_max;
    logic [IW-1:0]    upd_min_idx, upd_max_idx;

    logic             accept;
    logic             close_window;
    logic             keep_min, keep_max;

    // keep_min = min <= sample, keep_max = sample <= max; "<=" keeps the
    // earlier index on ties.
    LeCell #(.WIDTH(WIDTH)) u_le_min (
        .a  (min_r),
        .b  (in_data),
        .le (keep_min)
    );

    LeCell #(.WIDTH(WIDTH)) u_le_max (
        .a  (in_data),
        .b  (max_r),
        .le (keep_max)
    );

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == EMIT);
    assign accept    = in_valid && in_ready;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        upd_min     = min_r;
        upd_max     = max_r;
        upd_min_idx = min_idx_r;
        upd_max_idx = max_idx_r;
        upd_count   = count;

        if (accept) begin
            upd_count = count + CW'(1);
            if (count == '0) begin
                upd_min     = in_data;
                upd_max     = in_data;
                upd_min_idx = '0;
                upd_max_idx = '0;
            end else begin
                if (!keep_min) begin
                    upd_min     = in_data;
                    upd_min_idx = count[IW-1:0];
                end
                if (!keep_max) begin
                    upd_max     = in_data;
                    upd_max_idx = count[IW-1:0];
                end
            end
        end
    end

    // A flush with an empty window closes nothing unless a sample lands in
    // the same cycle.
    always_comb begin
        close_window = 1'b0;
        next_state   = state;

        case (state)
            COLLECT: begin
                close_window = (accept && (count == LAST_COUNT)) ||
                               (flush && ((count != '0) || accept));
                if (close_window) begin
                    next_state = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    next_state = COLLECT;
                end
            end
            default: next_state = COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= COLLECT;
            count       <= '0;
            min_r       <= '0;
            max_r       <= '0;
            min_idx_r   <= '0;
            max_idx_r   <= '0;
            out_min     <= '0;
            out_max     <= '0;
            out_min_idx <= '0;
            out_max_idx <= '0;
            out_count   <= '0;
        end else begin
            state <= next_state;

            if (state == COLLECT) begin
                count     <= upd_count;
                min_r     <= upd_min;
                max_r     <= upd_max;
                min_idx_r <= upd_min_idx;
                max_idx_r <= upd_max_idx;

                if (close_window) begin
                    out_min     <= upd_min;
                    out_max     <= upd_max;
                    out_min_idx <= upd_min_idx;
                    out_max_idx <= upd_max_idx;
                    out_count   <= upd_count;
                end
            end else if (out_ready) begin
                count <= '0;
            end
        end
    end

endmodule : le_window_extrema

// File: tb/tb_le_window_extrema.sv
// Directed self-checking bench for le_window_extrema with WIN=4, WIDTH=4.
module tb_le_window_extrema;

    localparam int WIDTH = 4;
    localparam int WIN   = 4;
    localparam int CW    = $clog2(WIN + 1);
    localparam int IW    = $clog2(WIN);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_min;
    logic [WIDTH-1:0] out_max;
    logic [IW-1:0]    out_min_idx;
    logic [IW-1:0]    out_max_idx;
    logic [CW-1:0]    out_count;

    int passed = 0;
    int total  = 0;

    le_window_extrema #(.WIDTH(WIDTH), .WIN(WIN)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_min     (out_min),
        .out_max     (out_max),
        .out_min_idx (out_min_idx),
        .out_max_idx (out_max_idx),
        .out_count   (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int mn, input int mn_idx,
                                 input int mx, input int mx_idx, input int cnt);
        check({tag, ".valid"},   32'(out_valid),   32'd1);
        check({tag, ".ready"},   32'(in_ready),    32'd0);
        check({tag, ".min"},     32'(out_min),     32'(mn));
        check({tag, ".min_idx"}, 32'(out_min_idx), 32'(mn_idx));
        check({tag, ".max"},     32'(out_max),     32'(mx));
        check({tag, ".max_idx"}, 32'(out_max_idx), 32'(mx_idx));
        check({tag, ".count"},   32'(out_count),   32'(cnt));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_min",   32'(out_min),   32'd0);
        check("rst.out_max",   32'(out_max),   32'd0);
        check("rst.out_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        tick();

        // Reset mid-window discards the partial window
        send(4'd5);
        send(4'd7);
        rst = 1'b1;
        #2;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.in_ready",  32'(in_ready),  32'd1);
        tick();
        rst = 1'b0;
        tick();
        send(4'd1);
        send(4'd2);
        send(4'd3);
        check("midrst.not_yet", 32'(out_valid), 32'd0);
        send(4'd4);
        expect_result("midrst", 1, 0, 4, 3, 4);
        consume();
        check("midrst.released", 32'(out_valid), 32'd0);

        // Basic window
        send(4'd2);
        send(4'd0);
        send(4'd3);
        check("basic.not_yet", 32'(out_valid), 32'd0);
        send(4'd4);
        expect_result("basic", 0, 1, 4, 3, 4);
        consume();

        // Ties keep earliest index
        send(4'd3);
        send(4'd1);
        send(4'd3);
        send(4'd1);
        expect_result("ties", 1, 1, 3, 0, 4);
        consume();

        // Flush together with an accept includes that sample
        send(4'd6);
        flush = 1'b1;
        send(4'd2);
        flush = 1'b0;
        expect_result("flush_acc", 2, 1, 6, 0, 2);
        consume();

        // Flush with an empty window is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_empty.valid", 32'(out_valid), 32'd0);
        check("flush_empty.ready", 32'(in_ready),  32'd1);

        // Flush with no accept but a non-empty window
        send(4'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_result("flush_alone", 9, 0, 9, 0, 1);
        consume();

        // Boundary values
        send(4'd15);
        send(4'd15);
        send(4'd0);
        send(4'd15);
        expect_result("boundary", 0, 2, 15, 0, 4);

        // Backpressure: a sample waits while the result is held; flush ignored
        in_valid = 1'b1;
        in_data  = 4'd5;
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            tick();
            expect_result("backpressure", 0, 2, 15, 0, 4);
        end
        flush = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp.released_valid", 32'(out_valid), 32'd0);
        check("bp.released_ready", 32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        send(4'd1);
        send(4'd8);
        check("bp.not_yet", 32'(out_valid), 32'd0);
        send(4'd3);
        expect_result("bp_next", 1, 1, 8, 2, 4);
        consume();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_le_window_extrema
